d3s_acq_sequencer: RTL

Sequencer for one D3S ADC acquisition buffer. It takes the ADC sample stream and, after a start command, writes samples circularly into the buffer RAM. It keeps a configurable pre-trigger history, accepts one trigger, captures a configurable number of post-trigger samples, then raises ready. It sits between the ADC deserializer and the acquisition buffer RAM; the host-side register bank drives it through the start/abort/ready control word.

---
 rtl/d3s_acq_sequencer_if.sv | 31 +++
 rtl/d3s_acq_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/d3s_acq_sequencer_if.sv
// Sample stream in from the ADC deserializer and write port out to the acquisition buffer RAM.
// The sequencer uses the slave view; the sample source / RAM side uses the master view.
interface d3s_acq_sequencer_if #(
    parameter int unsigned g_addr_width = 10,
    parameter int unsigned g_data_width = 16
);
    logic                    sample_valid;
    logic [g_data_width-1:0] sample;
    logic                    trig;
    logic                    ram_we;
    logic [g_addr_width-1:0] ram_addr;
    logic [g_data_width-1:0] ram_data;

    modport slave (
        input  sample_valid,
        input  sample,
        input  trig,
        output ram_we,
        output ram_addr,
        output ram_data
    );

    modport master (
        output sample_valid,
        output sample,
        output trig,
        input  ram_we,
        input  ram_addr,
        input  ram_data
    );
endinterface

// File: rtl/d3s_acq_sequencer.sv
// Pre/post-trigger acquisition sequencer: writes ADC samples circularly into the buffer RAM,
// records the trigger position and raises ready once the post-trigger window is captured.
module d3s_acq_sequencer #(
    parameter int unsigned g_addr_width = 10,
    parameter int unsigned g_data_width = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [g_addr_width-1:0] pre_samples_i,
    input  logic [g_addr_width:0]   post_samples_i,
    d3s_acq_sequencer_if.slave      bus_io,
    output logic                    busy_o,
    output logic                    ready_o,
    output logic                    error_o,
    output logic [g_addr_width-1:0] trig_addr_o,
    output logic [g_addr_width-1:0] start_addr_o
);
    localparam int unsigned CntW = g_addr_width + 1;
    localparam logic [g_addr_width+1:0] Depth = {2'b01, {g_addr_width{1'b0}}};

    typedef enum logic [2:0] {StIdle, StPreFill, StWaitTrig, StPost, StDone} state_e;

    state_e                  state_q;
    logic [g_addr_width-1:0] ptr_q;
    logic [CntW-1:0]         cnt_q;
    logic [g_addr_width-1:0] pre_q;
    logic [CntW-1:0]         post_q;
    logic                    ram_we_q;
    logic [g_addr_width-1:0] ram_addr_q;
    logic [g_data_width-1:0] ram_data_q;
    logic                    busy_q;
    logic                    ready_q;
    logic                    error_q;
    logic [g_addr_width-1:0] trig_addr_q;
    logic [g_addr_width-1:0] start_addr_q;

    logic [g_addr_width+1:0] cfg_sum;
    logic                    cfg_bad;
    logic                    capturing;
    logic                    wr_en;
    logic                    cnt_last;

    // Window must hold at least the trigger sample and fit the buffer without overwriting history.
    assign cfg_sum   = {2'b00, pre_samples_i} + {1'b0, post_samples_i};
    assign cfg_bad   = (post_samples_i == '0) || (cfg_sum > Depth);
    assign capturing = (state_q == StPreFill) || (state_q == StWaitTrig) || (state_q == StPost);
    assign wr_en     = capturing && bus_io.sample_valid && !abort_i;
    assign cnt_last  = (cnt_q == CntW'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            cnt_q        <= '0;
            pre_q        <= '0;
            post_q       <= '0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
        end else begin
            ram_we_q <= wr_en;
            if (wr_en) begin
                ram_addr_q <= ptr_q;
                ram_data_q <= bus_io.sample;
                ptr_q      <= ptr_q + g_addr_width'(1);
            end

            if (abort_i) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                ready_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StDone: begin
                        if (start_i) begin
                            pre_q   <= pre_samples_i;
                            post_q  <= post_samples_i;
                            cnt_q   <= {1'b0, pre_samples_i};
                            ptr_q   <= '0;
                            ready_q <= 1'b0;
                            error_q <= cfg_bad;
                            busy_q  <= !cfg_bad;
                            if (cfg_bad) begin
                                state_q <= StIdle;
                            end else if (pre_samples_i == '0) begin
                                state_q <= StWaitTrig;
                            end else begin
                                state_q <= StPreFill;
                            end
                        end
                    end
                    StPreFill: begin
                        if (bus_io.sample_valid) begin
                            cnt_q <= cnt_q - CntW'(1);
                            if (cnt_last) begin
                                state_q <= StWaitTrig;
                            end
                        end
                    end
                    StWaitTrig: begin
                        if (bus_io.sample_valid && bus_io.trig) begin
                            trig_addr_q  <= ptr_q;
                            start_addr_q <= ptr_q - pre_q;
                            cnt_q        <= post_q - CntW'(1);
                            if (post_q == CntW'(1)) begin
                                state_q <= StDone;
                                busy_q  <= 1'b0;
                                ready_q <= 1'b1;
                            end else begin
                                state_q <= StPost;
                            end
                        end
                    end
                    StPost: begin
                        if (bus_io.sample_valid) begin
                            cnt_q <= cnt_q - CntW'(1);
                            if (cnt_last) begin
                                state_q <= StDone;
                                busy_q  <= 1'b0;
                                ready_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus_io.ram_we   = ram_we_q;
    assign bus_io.ram_addr = ram_addr_q;
    assign bus_io.ram_data = ram_data_q;
    assign busy_o          = busy_q;
    assign ready_o         = ready_q;
    assign error_o         = error_q;
    assign trig_addr_o     = trig_addr_q;
    assign start_addr_o    = start_addr_q;
endmodule
